// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants, reset-level encodings and a width helper
// for the multi-channel button debouncer.
package debounce_pkg;

    // Default timing: 1200 clocks per tick is 100 us at 12 MHz.
    localparam int DEF_TICK_DIV     = 1200;
    localparam int DEF_STABLE_TICKS = 16;
    localparam int DEF_HOLD_TICKS   = 5000;

    // Level that the synchronisers and debounced outputs take on reset.
    typedef enum logic {
        LEVEL_LOW  = 1'b0,
        LEVEL_HIGH = 1'b1
    } reset_level_e;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// debounce_multi_if: button pins, enable and the debounced level/strobe
// outputs of debounce_multi bundled as one port.
interface debounce_multi_if #(
    parameter int NUM_CH = 4
) ();

    logic              en;
    logic [NUM_CH-1:0] btn_in;
    logic [NUM_CH-1:0] btn_level;
    logic [NUM_CH-1:0] btn_rise;
    logic [NUM_CH-1:0] btn_fall;
    logic [NUM_CH-1:0] btn_hold;

    // Board / consumer side: drives pins and enable, reads events.
    modport master (
        output en,
        output btn_in,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  btn_hold
    );

    // Debouncer side.
    modport slave (
        input  en,
        input  btn_in,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output btn_hold
    );

endinterface

// File: rtl/debounce_chan.sv
// debounce_chan: one button channel. Synchroniser chain, tick-driven
// stability counter, debounced level with rise/fall strobes, and a
// long-press hold counter that only exists when DEBOUNCE_HOLD_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int           SYNC_STAGES  = 2,
    parameter int           STABLE_TICKS = DEF_STABLE_TICKS,
    parameter reset_level_e RESET_LEVEL  = LEVEL_LOW
`ifdef DEBOUNCE_HOLD_EN
    ,
    parameter int           HOLD_TICKS   = DEF_HOLD_TICKS
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam logic RST_BIT = RESET_LEVEL;
    localparam int   CW      = clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          stab_cnt;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; keeps running regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    // Count consecutive disagreeing tick samples; accept the new level on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
            level    <= RST_BIT;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!en) begin
                stab_cnt <= '0;
            end else if (tick) begin
                if (s == level) begin
                    stab_cnt <= '0;
                end else if (stab_cnt == C_LAST) begin
                    level    <= s;
                    stab_cnt <= '0;
                    rise     <= s;
                    fall     <= ~s;
                end else begin
                    stab_cnt <= stab_cnt + CW'(1);
                end
            end
        end
    end

`ifdef DEBOUNCE_HOLD_EN
    localparam int HW = clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] H_MAX = HW'(HOLD_TICKS);

    logic [HW-1:0] hold_cnt;

    // Count ticks of a held press; pulse once when the count first reaches the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            hold     <= 1'b0;
        end else begin
            hold <= 1'b0;
            if (!en || !level) begin
                hold_cnt <= '0;
            end else if (tick && (hold_cnt != H_MAX)) begin
                hold_cnt <= hold_cnt + HW'(1);
                hold     <= (hold_cnt == (H_MAX - HW'(1)));
            end
        end
    end
`else
    assign hold = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button debouncer. One shared prescaler
// produces the sample tick; each channel is an independent debounce_chan.
// Define DEBOUNCE_HOLD_EN to build the per-channel long-press counters;
// otherwise btn_hold is constant 0.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int           NUM_CH       = 4,
    parameter int           SYNC_STAGES  = 2,
    parameter int           TICK_DIV     = DEF_TICK_DIV,
    parameter int           STABLE_TICKS = DEF_STABLE_TICKS,
    parameter reset_level_e RESET_LEVEL  = LEVEL_LOW,
    parameter int           HOLD_TICKS   = DEF_HOLD_TICKS
) (
    input  logic           clk,
    input  logic           rst_n,
    debounce_multi_if.slave bus
);

    localparam int PW = clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    // Reject parameter values outside the supported ranges at elaboration.
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("debounce_multi: NUM_CH must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("debounce_multi: SYNC_STAGES must be 2..4");
    end
    if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_tick_div
        $error("debounce_multi: TICK_DIV must be 1..65535");
    end
    if (STABLE_TICKS < 2 || STABLE_TICKS > 255) begin : g_bad_stable
        $error("debounce_multi: STABLE_TICKS must be 2..255");
    end
    if (HOLD_TICKS < 1) begin : g_bad_hold
        $error("debounce_multi: HOLD_TICKS must be at least 1");
    end

    logic [PW-1:0]     pre_cnt;
    logic              tick;
    logic [NUM_CH-1:0] level_v;
    logic [NUM_CH-1:0] rise_v;
    logic [NUM_CH-1:0] fall_v;
    logic [NUM_CH-1:0] hold_v;

    assign tick = bus.en && (pre_cnt == P_LAST);

    // Shared prescaler; parked at 0 while sampling is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (!bus.en || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_LEVEL  (RESET_LEVEL)
`ifdef DEBOUNCE_HOLD_EN
            ,
            .HOLD_TICKS   (HOLD_TICKS)
`endif
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bus.en),
            .tick  (tick),
            .pin   (bus.btn_in[i]),
            .level (level_v[i]),
            .rise  (rise_v[i]),
            .fall  (fall_v[i]),
            .hold  (hold_v[i])
        );
    end

    assign bus.btn_level = level_v;
    assign bus.btn_rise  = rise_v;
    assign bus.btn_fall  = fall_v;
    assign bus.btn_hold  = hold_v;

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: self-checking bench for debounce_multi with
// NUM_CH=2, TICK_DIV=4, STABLE_TICKS=3, HOLD_TICKS=5. Honours DEBOUNCE_HOLD_EN.
module tb_debounce_multi;
    import debounce_pkg::*;

    localparam int NCH  = 2;
    localparam int SYNC = 2;
    localparam int TD   = 4;
    localparam int ST   = 3;
    localparam int HT   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    debounce_multi_if #(.NUM_CH(NCH)) bus ();

    debounce_multi #(
        .NUM_CH       (NCH),
        .SYNC_STAGES  (SYNC),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .RESET_LEVEL  (LEVEL_LOW),
        .HOLD_TICKS   (HT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: what the outputs must be after each edge.
    logic [NCH-1:0] m_level, m_rise, m_fall, m_hold;
    logic [NCH-1:0] pin_q[$];
    logic [NCH-1:0] m_s;
    logic           m_tick;
    int             en_run;
    int             streak[NCH];
    int             held[NCH];

    // Event monitors used by the directed checks.
    int rise0_cnt, fall0_cnt, hold0_cnt, strobe_cnt;
    int rise11_seen, fall11_seen;
    int rise0_cyc, hold0_cyc;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at t=%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("[TB] FAIL %s at t=%0t: got %0d, want %0d..%0d", name, $time, act, lo, hi);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic [NCH-1:0] btn);
        @(posedge clk);
        #1;
        bus.en     = en;
        bus.btn_in = btn;
    endtask

    task automatic clear_counts();
        rise0_cnt = 0; fall0_cnt = 0; hold0_cnt = 0; strobe_cnt = 0;
        rise11_seen = 0; fall11_seen = 0;
    endtask

    // Count edges until btn_level[ch] reads val, or -1 on timeout.
    task automatic wait_level(input int ch, input logic val, input int limit, output int lat);
        lat = -1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.btn_level[ch] == val) begin
                lat = n;
                break;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: pins delayed by the synchroniser depth, sampled on ticks;
    // a new level is accepted after ST consecutive disagreeing samples.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_hold  = '0;
            pin_q.delete();
            for (int k = 0; k < SYNC; k++) pin_q.push_back('0);
            en_run = 0;
            for (int c = 0; c < NCH; c++) begin
                streak[c] = 0;
                held[c]   = 0;
            end
        end else begin
            m_s = pin_q[0];
            pin_q.push_back(bus.btn_in);
            void'(pin_q.pop_front());
            m_tick = bus.en && ((en_run % TD) == TD - 1);
            en_run = bus.en ? en_run + 1 : 0;
            m_rise = '0;
            m_fall = '0;
            m_hold = '0;
            for (int c = 0; c < NCH; c++) begin
`ifdef DEBOUNCE_HOLD_EN
                if (!bus.en || !m_level[c]) held[c] = 0;
                else if (m_tick && held[c] < HT) begin
                    held[c]++;
                    if (held[c] == HT) m_hold[c] = 1'b1;
                end
`endif
                if (!bus.en) streak[c] = 0;
                else if (m_tick) begin
                    if (m_s[c] != m_level[c]) begin
                        streak[c]++;
                        if (streak[c] == ST) begin
                            m_level[c] = m_s[c];
                            m_rise[c]  = m_s[c];
                            m_fall[c]  = ~m_s[c];
                            streak[c]  = 0;
                        end
                    end else begin
                        streak[c] = 0;
                    end
                end
            end
        end
    end

    // Compare every cycle against the model and collect event statistics.
    always @(negedge clk) begin
        check_output("level", bus.btn_level, m_level);
        check_output("rise",  bus.btn_rise,  m_rise);
        check_output("fall",  bus.btn_fall,  m_fall);
        check_output("hold",  bus.btn_hold,  m_hold);
        if (bus.btn_rise[0]) begin rise0_cnt++; rise0_cyc = cyc; end
        if (bus.btn_fall[0]) fall0_cnt++;
        if (bus.btn_hold[0]) begin hold0_cnt++; hold0_cyc = cyc; end
        if ((bus.btn_rise | bus.btn_fall) != '0) strobe_cnt++;
        if (bus.btn_rise == 2'b11) rise11_seen++;
        if (bus.btn_fall == 2'b11) fall11_seen++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog at t=%0t: simulation did not finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic [NCH-1:0] rnd;
        clear_counts();
        rise0_cyc = 0;
        hold0_cyc = 0;
        bus.en     = 1'b0;
        bus.btn_in = '0;
        rst_n      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("reset_level", bus.btn_level, 0);
        check_output("reset_strobes", bus.btn_rise | bus.btn_fall | bus.btn_hold, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        bus.en = 1'b1;
        repeat (10) @(posedge clk);

        // Clean step on channel 0
        clear_counts();
        apply_stimulus(1'b1, 2'b01);
        wait_level(0, 1'b1, 40, lat);
        check_range("step_latency", lat, 11, 14);
        check_output("step_rise_same_cycle", bus.btn_rise, 2'b01);
        check_output("step_ch1_level", bus.btn_level[1], 1'b0);
        repeat (10) @(posedge clk);
        check_output("step_rise_count", rise0_cnt, 1);
        apply_stimulus(1'b1, 2'b00);
        wait_level(0, 1'b0, 40, lat);
        check_range("release_latency", lat, 11, 14);
        repeat (5) @(posedge clk);

        // Glitches: 2 ticks high, 1 tick low, five times
        clear_counts();
        for (int r = 0; r < 5; r++) begin
            apply_stimulus(1'b1, 2'b01);
            repeat (7) @(posedge clk);
            apply_stimulus(1'b1, 2'b00);
            repeat (3) @(posedge clk);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_output("glitch_level", bus.btn_level[0], 1'b0);
        check_output("glitch_strobes", strobe_cnt, 0);

        // Simultaneous press and release on both channels
        clear_counts();
        apply_stimulus(1'b1, 2'b11);
        repeat (39) @(posedge clk);
        apply_stimulus(1'b1, 2'b00);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_output("both_rise_seen", rise11_seen, 1);
        check_output("both_fall_seen", fall11_seen, 1);
        check_output("both_rise0_count", rise0_cnt, 1);

        // Reset in the middle of a window
        apply_stimulus(1'b1, 2'b01);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);
        check_output("midreset_level", bus.btn_level, 0);
        check_output("midreset_strobes", strobe_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_level(0, 1'b1, 40, lat);
        check_range("midreset_relatency", lat, 11, 14);
        repeat (20) @(posedge clk);
        check_output("midreset_rise_count", rise0_cnt, 1);
        apply_stimulus(1'b1, 2'b00);
        repeat (30) @(posedge clk);

        // Sampling disabled while pins toggle
        clear_counts();
        for (int k = 0; k < 100; k++) begin
            rnd = NCH'($urandom);
            apply_stimulus(1'b0, rnd);
        end
        @(negedge clk);
        check_output("disabled_strobes", strobe_cnt, 0);
        check_output("disabled_level", bus.btn_level, 0);
        apply_stimulus(1'b0, 2'b11);
        repeat (4) @(posedge clk);
        apply_stimulus(1'b1, 2'b11);
        wait_level(0, 1'b1, 40, lat);
        check_output("enable_latency", lat, 12);

        // Long press
        clear_counts();
        repeat (60) @(posedge clk);
        @(negedge clk);
`ifdef DEBOUNCE_HOLD_EN
        check_output("hold_count", hold0_cnt, 1);
        check_output("hold_distance", hold0_cyc - rise0_cyc, 20);
`else
        check_output("hold_count", hold0_cnt, 0);
`endif

        // Randomised segments checked by the model
        apply_stimulus(1'b1, 2'b00);
        repeat (30) @(posedge clk);
        for (int seg = 0; seg < 150; seg++) begin
            int dur;
            rnd = NCH'($urandom);
            dur = $urandom_range(1, 30);
            apply_stimulus($urandom_range(0, 9) != 0, rnd);
            repeat (dur - 1) @(posedge clk);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
